// File: rtl/state_log_pkg.sv
// Shared definitions for the state logging blocks: history FSM encoding and entry width.
package state_log_pkg;

   typedef enum logic [1:0] {
      StArmed  = 2'd0,
      StPost   = 2'd1,
      StFrozen = 2'd2
   } hist_state_e;

   function automatic int unsigned ENTRY_W(input int unsigned bits, input int unsigned ts_bits);
      return 2 * bits + ts_bits;
   endfunction

endpackage

// File: rtl/state_hist_ram.sv
// History storage: one synchronous write port, one asynchronous read port, no reset.
module state_hist_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/state_transition_history.sv
// Timestamped ring buffer of state transitions with trigger-then-freeze capture of fault history.
module state_transition_history
   import state_log_pkg::*;
#(
   parameter int unsigned BITS      = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned TS_BITS   = 16,
   parameter int unsigned POST_TRIG = 4
) (
   input  logic                        iClk,
   input  logic                        iRst_n,
   input  logic                        iClear,
   input  logic [BITS-1:0]             iPrevState,
   input  logic [BITS-1:0]             iCurrState,
   input  logic                        iTrigger,
   input  logic                        iRdAck,
   output logic                        oRdValid,
   output logic [2*BITS+TS_BITS-1:0]   oRdData,
   output logic [$clog2(DEPTH):0]      oCount,
   output logic                        oOverflow,
   output logic                        oFrozen
);

   localparam int unsigned EntryW = ENTRY_W(BITS, TS_BITS);
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned RemW   = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

   logic [TS_BITS-1:0] ts_q, ts_d;
   logic               primed_q, primed_d;
   logic [BITS-1:0]    last_curr_q, last_curr_d;
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]      count_q, count_d;
   logic               ovf_q, ovf_d;
   hist_state_e        state_q, state_d;
   logic [RemW-1:0]    rem_q, rem_d;

   logic               full, capture, wr_en, pop;
   logic [EntryW-1:0]  rd_data;

   assign full    = (count_q == (PtrW + 1)'(DEPTH));
   assign capture = primed_q && (iCurrState != last_curr_q);
   assign wr_en   = capture && (state_q != StFrozen) && !iClear;
   assign pop     = iRdAck && (count_q != '0) && !iClear;

   always_comb begin
      ts_d        = ts_q + TS_BITS'(1);
      primed_d    = 1'b1;
      last_curr_d = iCurrState;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      state_d     = state_q;
      rem_d       = rem_q;
      if (iClear) begin
         ts_d        = '0;
         primed_d    = 1'b0;
         last_curr_d = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         ovf_d       = 1'b0;
         state_d     = StArmed;
         rem_d       = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         // A write into a full buffer evicts the head exactly like a pop does.
         if (pop || (wr_en && full)) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (wr_en && full && !pop) begin
            ovf_d = 1'b1;
         end
         if (wr_en && !pop && !full) begin
            count_d = count_q + (PtrW + 1)'(1);
         end else if (pop && !wr_en) begin
            count_d = count_q - (PtrW + 1)'(1);
         end
         case (state_q)
            StArmed: begin
               if (iTrigger) begin
                  if (POST_TRIG == 0) begin
                     state_d = StFrozen;
                  end else begin
                     state_d = StPost;
                     rem_d   = RemW'(POST_TRIG);
                  end
               end
            end
            StPost: begin
               if (wr_en) begin
                  if (rem_q == RemW'(1)) begin
                     state_d = StFrozen;
                  end else begin
                     rem_d = rem_q - RemW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         ts_q        <= '0;
         primed_q    <= 1'b0;
         last_curr_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         state_q     <= StArmed;
         rem_q       <= '0;
      end else begin
         ts_q        <= ts_d;
         primed_q    <= primed_d;
         last_curr_q <= last_curr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         rem_q       <= rem_d;
      end
   end

   state_hist_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EntryW),
      .AW    (PtrW)
   ) u_ram (
      .clk_i     (iClk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i ({iPrevState, iCurrState, ts_q}),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   // RAM has no reset; gate the read data so an empty buffer presents zero.
   assign oRdValid  = (count_q != '0);
   assign oRdData   = oRdValid ? rd_data : '0;
   assign oCount    = count_q;
   assign oOverflow = ovf_q;
   assign oFrozen   = (state_q == StFrozen);

endmodule

// File: tb/tb_state_transition_history.sv
// Directed and randomized checks of the transition history buffer against a queue-based model.
module tb_state_transition_history;

   localparam int unsigned BITS      = 8;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned TS_BITS   = 16;
   localparam int unsigned POST_TRIG = 2;

   logic        iClk = 1'b0;
   logic        iRst_n = 1'b0;
   logic        iClear = 1'b0;
   logic [7:0]  iPrevState = '0;
   logic [7:0]  iCurrState = '0;
   logic        iTrigger = 1'b0;
   logic        iRdAck = 1'b0;
   logic        oRdValid;
   logic [31:0] oRdData;
   logic [2:0]  oCount;
   logic        oOverflow;
   logic        oFrozen;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_q[$];
   int          m_ts;
   bit          m_primed;
   logic [7:0]  m_last;
   bit          m_ovf;
   bit          m_post;
   bit          m_frozen;
   int          m_left;

   logic [7:0]  cur;

   state_transition_history #(
      .BITS      (BITS),
      .DEPTH     (DEPTH),
      .TS_BITS   (TS_BITS),
      .POST_TRIG (POST_TRIG)
   ) dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iClear     (iClear),
      .iPrevState (iPrevState),
      .iCurrState (iCurrState),
      .iTrigger   (iTrigger),
      .iRdAck     (iRdAck),
      .oRdValid   (oRdValid),
      .oRdData    (oRdData),
      .oCount     (oCount),
      .oOverflow  (oOverflow),
      .oFrozen    (oFrozen)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_ts     = 0;
      m_primed = 0;
      m_last   = '0;
      m_ovf    = 0;
      m_post   = 0;
      m_frozen = 0;
      m_left   = 0;
   endtask

   task automatic model_edge(input logic [7:0] prev, input logic [7:0] curr,
                             input bit trig, input bit ack, input bit clr);
      bit wr, pp;
      if (clr) begin
         model_clear();
      end else begin
         wr = m_primed && (curr != m_last) && !m_frozen;
         pp = ack && (m_q.size() > 0);
         if (pp) void'(m_q.pop_front());
         if (wr) begin
            if (m_q.size() == DEPTH) begin
               void'(m_q.pop_front());
               m_ovf = 1;
            end
            m_q.push_back({prev, curr, 16'(m_ts)});
         end
         if (!m_post && !m_frozen) begin
            if (trig) begin
               if (POST_TRIG == 0) m_frozen = 1;
               else begin
                  m_post = 1;
                  m_left = POST_TRIG;
               end
            end
         end else if (m_post && wr) begin
            m_left--;
            if (m_left == 0) begin
               m_post   = 0;
               m_frozen = 1;
            end
         end
         m_last   = curr;
         m_primed = 1;
         m_ts     = (m_ts + 1) % 65536;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, 64'(oRdValid), 64'(m_q.size() > 0));
      check({tag, ".count"}, 64'(oCount), 64'(m_q.size()));
      check({tag, ".ovf"}, 64'(oOverflow), 64'(m_ovf));
      check({tag, ".frozen"}, 64'(oFrozen), 64'(m_frozen));
      check({tag, ".data"}, 64'(oRdData), (m_q.size() > 0) ? 64'(m_q[0]) : 64'h0);
   endtask

   task automatic step(input logic [7:0] prev, input logic [7:0] curr, input bit trig,
                       input bit ack, input bit clr, input bit chk, input string tag);
      iPrevState = prev;
      iCurrState = curr;
      iTrigger   = trig;
      iRdAck     = ack;
      iClear     = clr;
      @(posedge iClk);
      model_edge(prev, curr, trig, ack, clr);
      @(negedge iClk);
      if (chk) check_all(tag);
   endtask

   // Logs a transition from cur to v, optionally with trigger/ack.
   task automatic change(input logic [7:0] v, input bit trig, input bit ack, input string tag);
      step(cur, v, trig, ack, 1'b0, 1'b1, tag);
      cur = v;
   endtask

   task automatic do_reset(input string tag);
      iRst_n = 1'b0;
      #1;
      model_clear();
      check_all(tag);
      @(posedge iClk);
      @(negedge iClk);
      iRst_n = 1'b1;
   endtask

   initial begin
      cur = 8'h00;
      do_reset("reset");
      check("reset_count", 64'(oCount), 64'd0);
      check("reset_valid", 64'(oRdValid), 64'd0);

      // Single entry at timestamp 10, then pop it.
      for (int i = 0; i < 10; i++) step(8'h00, 8'h00, 0, 0, 0, 1, "idle");
      change(8'h11, 0, 0, "first");
      check("first_entry", 64'(oRdData), 64'h0011_000A);
      check("first_count", 64'(oCount), 64'd1);
      step(cur, cur, 0, 1, 0, 1, "pop1");
      check("pop1_count", 64'(oCount), 64'd0);

      // Six changes without pops overflow a 4-deep buffer.
      for (int v = 1; v <= 6; v++) change(8'(v), 0, 0, "fill");
      check("ovf_count", 64'(oCount), 64'd4);
      check("ovf_flag", 64'(oOverflow), 64'd1);
      check("ovf_head", 64'(oRdData[31:16]), 64'h0203);

      // Full buffer: capture and pop in the same cycle.
      step(cur, cur, 0, 0, 1, 1, "clear1");
      step(cur, cur, 0, 0, 0, 1, "prime1");
      for (int v = 8'h21; v <= 8'h24; v++) change(8'(v), 0, 0, "fill2");
      change(8'h25, 0, 1, "cap_pop");
      check("cap_pop_count", 64'(oCount), 64'd4);
      check("cap_pop_ovf", 64'(oOverflow), 64'd0);
      check("cap_pop_head", 64'(oRdData[31:16]), 64'h2122);

      // Trigger then three changes: two logged, third dropped once frozen.
      step(cur, cur, 1, 0, 0, 1, "trig");
      change(8'h31, 0, 0, "post1");
      check("post1_frozen", 64'(oFrozen), 64'd0);
      change(8'h32, 0, 0, "post2");
      check("post2_frozen", 64'(oFrozen), 64'd1);
      change(8'h33, 0, 0, "post3");
      check("post3_head", 64'(oRdData[31:16]), 64'h2324);
      check("post3_count", 64'(oCount), 64'd4);
      step(cur, cur, 0, 0, 1, 1, "clear2");
      check("clear2_frozen", 64'(oFrozen), 64'd0);
      check("clear2_count", 64'(oCount), 64'd0);

      // Constant non-zero state across reset release must not log.
      cur = 8'h5A;
      iCurrState = 8'h5A;
      do_reset("reset2");
      for (int i = 0; i < 3; i++) step(8'h00, 8'h5A, 0, 0, 0, 1, "prime2");
      check("prime2_valid", 64'(oRdValid), 64'd0);

      // Randomized traffic, with one asynchronous reset mid-run.
      for (int i = 0; i < 800; i++) begin
         logic [7:0] nv;
         bit         t, a, c;
         nv = ($urandom_range(0, 99) < 50) ? 8'($urandom_range(0, 255)) : cur;
         a  = ($urandom_range(0, 3) == 0);
         t  = ($urandom_range(0, 29) == 0);
         c  = ($urandom_range(0, 79) == 0);
         step(8'($urandom_range(0, 255)), nv, t, a, c, 1, "rand");
         cur = nv;
         if (i == 400) do_reset("rand_reset");
      end

      // Timestamp wrap: captures at FFFF and at the following 0000.
      step(cur, cur, 0, 0, 1, 1, "clear3");
      for (int i = 0; i < 65535; i++) step(cur, cur, 0, 0, 0, 0, "wrap_idle");
      check_all("wrap_idle_end");
      change(cur + 8'h01, 0, 0, "wrap_a");
      check("wrap_ts_ffff", 64'(oRdData[15:0]), 64'hFFFF);
      change(cur + 8'h01, 0, 0, "wrap_b");
      step(cur, cur, 0, 1, 0, 1, "wrap_pop");
      check("wrap_ts_0000", 64'(oRdData[15:0]), 64'h0000);
      check("wrap_count", 64'(oCount), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
